// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg : MemOP encodings and responder FSM state type.  Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_lane_align : store byte-enable/shift, load extract/extend.  Rev 1.0
// ------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword >> {addr_lo, 3'b000};
    wword   = wdata << {addr_lo, 3'b000};
    be      = 4'b0000;
    rdata   = '0;
    err     = 1'b1;
    case (memop)
      MEMOP_B: begin
        be    = 4'b0001 << addr_lo;
        rdata = {{24{shifted[7]}}, shifted[7:0]};
        err   = 1'b0;
      end
      MEMOP_H: begin
        be    = 4'b0011 << addr_lo;
        rdata = {{16{shifted[15]}}, shifted[15:0]};
        err   = addr_lo[0];
      end
      MEMOP_W: begin
        be    = 4'b1111;
        rdata = shifted;
        err   = |addr_lo;
      end
      // Unsigned forms exist only for loads.
      MEMOP_BU: begin
        rdata = {24'd0, shifted[7:0]};
        err   = we;
      end
      MEMOP_HU: begin
        rdata = {16'd0, shifted[15:0]};
        err   = we | addr_lo[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// data_mem_responder : valid/ready byte-addressed data memory.  Rev 1.0
// ------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        memop_q, memop_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live request is used so a zero-wait access commits on accept.
  logic        cur_we;
  logic [2:0]  cur_memop;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] idx;
  logic        in_range;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] ld_data;
  logic        op_err;
  logic        req_err;
  logic        commit;
  logic        mem_wr;

  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_memop = (state_q == IDLE) ? req_memop : memop_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign idx       = cur_addr[AW+1:2];
  assign in_range  = cur_addr[31:2] < 30'(DEPTH_WORDS);
  assign rword     = mem[idx];
  assign req_err   = op_err | ~in_range;

  mem_lane_align u_align (
    .we      (cur_we),
    .memop   (cur_memop),
    .addr_lo (cur_addr[1:0]),
    .wdata   (cur_wdata),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .rdata   (ld_data),
    .err     (op_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    memop_d      = memop_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          memop_d = req_memop;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) commit = 1'b1;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = req_err;
      resp_rdata_d = (req_err || cur_we) ? '0 : ld_data;
    end
  end

  assign mem_wr = commit & cur_we & ~req_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      memop_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      memop_q      <= memop_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage has no reset; a store caught by reset never reaches it.
  always_ff @(posedge clk) begin
    if (rst && mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
